// File: rtl/layer_pkg.sv
// Shared types for the layer sequencer. The state encoding is visible to the
// network controller for debug and status reporting.
package layer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    ACCUM    = 3'd2,
    DRAIN    = 3'd3,
    BIAS     = 3'd4,
    ACTIVATE = 3'd5,
    HOLD     = 3'd6
  } layer_state_t;

endpackage

// File: rtl/layer_sequencer_index_counter.sv
// Up counter with a synchronous clear. It saturates at MAX, so it can never
// reach an address above MAX.
module index_counter #(
  parameter int unsigned MAX   = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_enable && (r_count != WIDTH'(MAX)))
      r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: clear, accumulate, drain the MAC pipeline,
// add bias, activate, then hold the result until the next layer accepts it.
module layer_sequencer
  import layer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned MAC_LATENCY = 1,
  parameter int unsigned INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   ready,
  output logic [INDEX_WIDTH-1:0] input_index,
  output logic                   mac_clear,
  output logic                   mac_enable,
  output logic                   bias_enable,
  output logic                   relu_reset_output,
  output logic                   relu_enable,
  output logic                   out_valid
);

  localparam int unsigned DRAIN_WIDTH = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;
  localparam int unsigned DRAIN_MAX   = (MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0;

  layer_state_t r_state;
  logic r_abort_flush;

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [DRAIN_WIDTH-1:0] w_drn;
  logic w_idx_term;
  logic w_drn_term;

  assign w_idx_term = (w_idx == INDEX_WIDTH'(NUM_INPUTS - 1));
  assign w_drn_term = (w_drn == DRAIN_WIDTH'(DRAIN_MAX));

  // Counters are held at zero outside their own state and cleared on their last
  // cycle, so each phase always starts from zero without extra bookkeeping.
  index_counter #(
    .MAX   (NUM_INPUTS - 1),
    .WIDTH (INDEX_WIDTH)
  ) u_index_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (abort || (r_state != ACCUM) || w_idx_term),
    .i_enable (r_state == ACCUM),
    .o_count  (w_idx)
  );

  index_counter #(
    .MAX   (DRAIN_MAX),
    .WIDTH (DRAIN_WIDTH)
  ) u_drain_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (abort || (r_state != DRAIN) || w_drn_term),
    .i_enable (r_state == DRAIN),
    .o_count  (w_drn)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_abort_flush <= 1'b0;
    end else begin
      r_abort_flush <= abort;
      if (abort) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          IDLE:     if (start) r_state <= CLEAR;
          CLEAR:    r_state <= ACCUM;
          ACCUM:    if (w_idx_term) r_state <= (MAC_LATENCY == 0) ? BIAS : DRAIN;
          DRAIN:    if (w_drn_term) r_state <= BIAS;
          BIAS:     r_state <= ACTIVATE;
          ACTIVATE: r_state <= HOLD;
          HOLD:     if (out_ready) r_state <= IDLE;
          default:  r_state <= IDLE;
        endcase
      end
    end
  end

  // The abort flush flag zeroes the ReLU stage for the cycle after a cancel.
  always_comb begin
    ready             = (r_state == IDLE);
    input_index       = (r_state == ACCUM) ? w_idx : '0;
    mac_clear         = (r_state == CLEAR);
    mac_enable        = (r_state == ACCUM);
    bias_enable       = (r_state == BIAS);
    relu_reset_output = (r_state == CLEAR) || r_abort_flush;
    relu_enable       = (r_state == ACTIVATE);
    out_valid         = (r_state == HOLD);
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed tests for layer_sequencer in two configurations: (4 inputs, latency 1)
// and (1 input, latency 0).
module tb_layer_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       a_start = 1'b0, a_abort = 1'b0, a_out_ready = 1'b0;
  logic       a_ready, a_mac_clear, a_mac_enable, a_bias_enable;
  logic       a_relu_reset_output, a_relu_enable, a_out_valid;
  logic [1:0] a_input_index;

  logic       b_start = 1'b0, b_abort = 1'b0, b_out_ready = 1'b0;
  logic       b_ready, b_mac_clear, b_mac_enable, b_bias_enable;
  logic       b_relu_reset_output, b_relu_enable, b_out_valid;
  logic [0:0] b_input_index;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  layer_sequencer #(.NUM_INPUTS(4), .MAC_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
    .out_ready(a_out_ready), .ready(a_ready), .input_index(a_input_index),
    .mac_clear(a_mac_clear), .mac_enable(a_mac_enable), .bias_enable(a_bias_enable),
    .relu_reset_output(a_relu_reset_output), .relu_enable(a_relu_enable),
    .out_valid(a_out_valid)
  );

  layer_sequencer #(.NUM_INPUTS(1), .MAC_LATENCY(0)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
    .out_ready(b_out_ready), .ready(b_ready), .input_index(b_input_index),
    .mac_clear(b_mac_clear), .mac_enable(b_mac_enable), .bias_enable(b_bias_enable),
    .relu_reset_output(b_relu_reset_output), .relu_enable(b_relu_enable),
    .out_valid(b_out_valid)
  );

  // Output vector: ready, mac_clear, mac_enable, bias_enable, relu_reset_output,
  // relu_enable, out_valid, input_index[1:0]
  logic [8:0] obs_a, obs_b;
  assign obs_a = {a_ready, a_mac_clear, a_mac_enable, a_bias_enable,
                  a_relu_reset_output, a_relu_enable, a_out_valid, a_input_index};
  assign obs_b = {b_ready, b_mac_clear, b_mac_enable, b_bias_enable,
                  b_relu_reset_output, b_relu_enable, b_out_valid, 1'b0, b_input_index};

  localparam logic [8:0] V_IDLE  = 9'b1_0000_0000;
  localparam logic [8:0] V_ABRT  = 9'b1_0001_0000;
  localparam logic [8:0] V_CLR   = 9'b0_1001_0000;
  localparam logic [8:0] V_ACC0  = 9'b0_0100_0000;
  localparam logic [8:0] V_ACC1  = 9'b0_0100_0001;
  localparam logic [8:0] V_ACC2  = 9'b0_0100_0010;
  localparam logic [8:0] V_ACC3  = 9'b0_0100_0011;
  localparam logic [8:0] V_DRN   = 9'b0_0000_0000;
  localparam logic [8:0] V_BIAS  = 9'b0_0010_0000;
  localparam logic [8:0] V_ACT   = 9'b0_0000_1000;
  localparam logic [8:0] V_HOLD  = 9'b0_0000_0100;

  // Outputs after each edge from E0 (start sampled) through the first HOLD cycle.
  logic [8:0] pass_a [10] = '{V_CLR, V_ACC0, V_ACC1, V_ACC2, V_ACC3,
                              V_DRN, V_BIAS, V_ACT, V_HOLD, V_IDLE};
  logic [8:0] pass_b [5]  = '{V_CLR, V_ACC0, V_BIAS, V_ACT, V_HOLD};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL reset_a: got %b expected %b", obs_a, V_IDLE);
    end
    checks++;
    if (obs_b !== V_IDLE) begin
      errors++;
      $display("FAIL reset_b: got %b expected %b", obs_b, V_IDLE);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_pass;
    a_start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      a_start = 1'b0;
      checks++;
      if (obs_a !== pass_a[i]) begin
        errors++;
        $display("FAIL basic_pass[%0d]: got %b expected %b", i, obs_a, pass_a[i]);
      end
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL basic_release: got %b expected %b", obs_a, V_IDLE);
    end
  endtask

  task automatic test_zero_latency;
    b_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      b_start = 1'b0;
      checks++;
      if (obs_b !== pass_b[i]) begin
        errors++;
        $display("FAIL zero_latency[%0d]: got %b expected %b", i, obs_b, pass_b[i]);
      end
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    checks++;
    if (obs_b !== V_IDLE) begin
      errors++;
      $display("FAIL zero_latency_release: got %b expected %b", obs_b, V_IDLE);
    end
  endtask

  task automatic test_backpressure;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs_a !== V_HOLD) begin
        errors++;
        $display("FAIL backpressure[%0d]: got %b expected %b", i, obs_a, V_HOLD);
      end
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL backpressure_release: got %b expected %b", obs_a, V_IDLE);
    end
  endtask

  task automatic test_back_to_back;
    a_start     = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_a !== pass_a[i % 10]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs_a, pass_a[i % 10]);
      end
    end
    a_start     = 1'b0;
    a_out_ready = 1'b0;
    tick();
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL back_to_back_stop: got %b expected %b", obs_a, V_IDLE);
    end
  endtask

  task automatic test_abort;
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    checks++;
    if (obs_a !== V_ABRT) begin
      errors++;
      $display("FAIL abort_idle: got %b expected %b", obs_a, V_ABRT);
    end
    tick();
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL abort_idle_after: got %b expected %b", obs_a, V_IDLE);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_a !== V_ACC2) begin
      errors++;
      $display("FAIL abort_reach_idx2: got %b expected %b", obs_a, V_ACC2);
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    checks++;
    if (obs_a !== V_ABRT) begin
      errors++;
      $display("FAIL abort_accum: got %b expected %b", obs_a, V_ABRT);
    end
    tick();
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL abort_accum_after: got %b expected %b", obs_a, V_IDLE);
    end
    a_start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      a_start = 1'b0;
      checks++;
      if (obs_a !== pass_a[i]) begin
        errors++;
        $display("FAIL abort_rerun[%0d]: got %b expected %b", i, obs_a, pass_a[i]);
      end
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs_a !== V_DRN) begin
      errors++;
      $display("FAIL async_reach_drain: got %b expected %b", obs_a, V_DRN);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", obs_a, V_IDLE);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (obs_a !== V_IDLE) begin
      errors++;
      $display("FAIL async_reset_after: got %b expected %b", obs_a, V_IDLE);
    end
    a_start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      a_start = 1'b0;
      checks++;
      if (obs_a !== pass_a[i]) begin
        errors++;
        $display("FAIL async_rerun[%0d]: got %b expected %b", i, obs_a, pass_a[i]);
      end
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_zero_latency();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
